// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer that shares one combinational 32-bit ALU between two
// masters and returns each result on a tagged valid/ready response channel.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic             rsp_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_binvert,
  output logic             alu_carryin,
  output logic [1:0]       alu_operation,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carryout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             owner_q, owner_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_carry_q, rsp_carry_d;
  logic             rsp_err_q, rsp_err_d;

  logic grant;
  logic idle;
  logic transfer;
  logic op_legal;

  // Under contention the master not served last wins; otherwise whoever is valid.
  always_comb begin
    if (req0_valid && req1_valid) grant = ~last_grant_q;
    else                          grant = req1_valid;
  end

  // Ready is gated by reset so it reads 0 while reset is held, like every other output.
  assign idle       = (state_q == IDLE) && !reset;
  assign req0_ready = idle && req0_valid && !grant;
  assign req1_ready = idle && req1_valid && grant;
  assign transfer   = req0_ready || req1_ready;

  always_comb begin
    case (op_q)
      3'b000, 3'b001, 3'b010, 3'b110: op_legal = 1'b1;
      default:                        op_legal = 1'b0;
    endcase
  end

  always_comb begin
    // NOTE: every next-state signal takes its hold value first, so no path can infer a latch.
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_err_d    = rsp_err_q;

    case (state_q)
      IDLE: begin
        if (transfer) begin
          op_d         = grant ? req1_op : req0_op;
          a_d          = grant ? req1_a  : req0_a;
          b_d          = grant ? req1_b  : req0_b;
          owner_d      = grant;
          last_grant_d = grant;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        rsp_id_d = owner_q;
        if (op_legal) begin
          rsp_result_d = alu_result;
          rsp_carry_d  = alu_carryout;
          rsp_err_d    = 1'b0;
        end else begin
          rsp_result_d = '0;
          rsp_carry_d  = 1'b0;
          rsp_err_d    = 1'b1;
        end
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: operand registers are reset too, because they drive the ALU inputs visible at reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      op_q         <= 3'b000;
      a_q          <= '0;
      b_q          <= '0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign alu_a         = a_q;
  assign alu_b         = b_q;
  assign alu_binvert   = op_q[2];
  assign alu_carryin   = op_q[2];
  assign alu_operation = op_q[1:0];

  assign rsp_valid  = (state_q == RESP);
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_carry  = rsp_carry_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: behavioural ALU attached to the DUT and an
// arithmetic reference model for every response.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [2:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_err;
  logic [31:0] rsp_result;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        alu_binvert, alu_carryin, alu_carryout;
  logic [1:0]  alu_operation;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_binvert(alu_binvert), .alu_carryin(alu_carryin),
    .alu_operation(alu_operation), .alu_result(alu_result), .alu_carryout(alu_carryout)
  );

  // Shared ALU: ripple adder carry is always produced, result picked by Operation.
  logic [31:0] alu_bb;
  logic [32:0] alu_sum;
  always_comb begin
    alu_bb  = alu_binvert ? ~alu_b : alu_b;
    alu_sum = {1'b0, alu_a} + {1'b0, alu_bb} + {32'b0, alu_carryin};
    case (alu_operation)
      2'b00:   alu_result = alu_a & alu_bb;
      2'b01:   alu_result = alu_a | alu_bb;
      2'b10:   alu_result = alu_sum[31:0];
      default: alu_result = {31'b0, alu_sum[31]};
    endcase
    alu_carryout = alu_sum[32];
  end

  // Expected {err, carry, result} straight from the op-code meaning.
  function automatic logic [33:0] ref_rsp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    case (op)
      3'b000:  return {1'b0, s[32], a & b};
      3'b001:  return {1'b0, s[32], a | b};
      3'b010:  return {1'b0, s};
      3'b110:  return {1'b0, (a >= b), a - b};
      default: return {2'b10, 32'h0};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request from master m and return just after the accepting edge (in EXEC).
  task automatic accept(input bit m, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int waits);
    if (m) begin req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1; end
    else   begin req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1; end
    waits = 0;
    @(negedge clk);
    while (!(m ? req1_ready : req0_ready) && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    chk("grant_timeout", 32'(waits < 20), 32'd1);
    chk("grant_exclusive", m ? req0_ready : req1_ready, 32'd0);
    @(posedge clk); #1;
    if (m) req1_valid = 1'b0;
    else   req0_valid = 1'b0;
  endtask

  // Check the EXEC cycle, the response, stall cycles, and the handshake.
  task automatic exec_resp(input bit m, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input int stall);
    logic [33:0] e;
    e = ref_rsp(op, a, b);
    @(negedge clk);
    chk("exec_alu_a", alu_a, a);
    chk("exec_alu_b", alu_b, b);
    chk("exec_binvert", alu_binvert, op[2]);
    chk("exec_carryin", alu_carryin, op[2]);
    chk("exec_operation", alu_operation, op[1:0]);
    chk("exec_rsp_valid", rsp_valid, 32'd0);
    rsp_ready = (stall == 0);
    @(negedge clk);
    chk("rsp_valid", rsp_valid, 32'd1);
    chk("rsp_id", rsp_id, m);
    chk("rsp_result", rsp_result, e[31:0]);
    chk("rsp_carry", rsp_carry, e[32]);
    chk("rsp_err", rsp_err, e[33]);
    for (int i = 1; i < stall; i++) begin
      @(negedge clk);
      chk("stall_valid", rsp_valid, 32'd1);
      chk("stall_result", rsp_result, e[31:0]);
      chk("stall_id", rsp_id, m);
      chk("stall_ready0", req0_ready, 32'd0);
      chk("stall_ready1", req1_ready, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("after_handshake_valid", rsp_valid, 32'd0);
  endtask

  logic [2:0] legal_ops [4] = '{3'b000, 3'b001, 3'b010, 3'b110};

  initial begin
    int w;
    logic [33:0] e;
    logic [31:0] ra, rb;
    logic [2:0]  rop;
    bit          rm, win;

    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    req0_op = '0; req0_a = '0; req0_b = '0;
    req1_op = '0; req1_a = '0; req1_b = '0;
    @(negedge clk);
    chk("reset_rsp_valid", rsp_valid, 32'd0);
    chk("reset_ready0", req0_ready, 32'd0);
    chk("reset_ready1", req1_ready, 32'd0);
    chk("reset_rsp_result", rsp_result, 32'd0);
    chk("reset_rsp_flags", {rsp_id, rsp_carry, rsp_err}, 32'd0);
    chk("reset_alu_a", alu_a, 32'd0);
    chk("reset_alu_b", alu_b, 32'd0);
    chk("reset_alu_ctl", {alu_binvert, alu_carryin, alu_operation}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed single ops from master 0.
    for (int i = 0; i < 4; i++) begin
      accept(1'b0, legal_ops[i], 32'hA5A5A5A5, 32'h5A5A5A5A, w);
      exec_resp(1'b0, legal_ops[i], 32'hA5A5A5A5, 32'h5A5A5A5A, 0);
    end
    e = ref_rsp(3'b110, 32'hA5A5A5A5, 32'h5A5A5A5A);
    chk("sub_golden", e[32:0], {1'b1, 32'h4B4B4B4B});

    // Illegal op codes, then a legal op.
    accept(1'b0, 3'b011, 32'hFFFF0000, 32'h0F0F0F0F, w);
    exec_resp(1'b0, 3'b011, 32'hFFFF0000, 32'h0F0F0F0F, 0);
    accept(1'b1, 3'b100, 32'hFFFF0000, 32'h0F0F0F0F, w);
    exec_resp(1'b1, 3'b100, 32'hFFFF0000, 32'h0F0F0F0F, 0);
    accept(1'b0, 3'b110, 32'd5, 32'd7, w);
    exec_resp(1'b0, 3'b110, 32'd5, 32'd7, 0);

    // Backpressure with master 1 waiting; it is accepted right after the handshake.
    accept(1'b0, 3'b010, 32'h8000_0000, 32'h8000_0001, w);
    req1_op = 3'b001; req1_a = 32'h00F0_0000; req1_b = 32'h0000_000F; req1_valid = 1'b1;
    exec_resp(1'b0, 3'b010, 32'h8000_0000, 32'h8000_0001, 5);
    accept(1'b1, 3'b001, 32'h00F0_0000, 32'h0000_000F, w);
    chk("accept_after_handshake", w, 32'd0);
    exec_resp(1'b1, 3'b001, 32'h00F0_0000, 32'h0000_000F, 0);

    // Master 1 drops valid while master 0 is busy.
    accept(1'b0, 3'b001, 32'h1234_0000, 32'h0000_5678, w);
    req1_op = 3'b010; req1_a = 32'hFFFF_FFFF; req1_b = 32'd1; req1_valid = 1'b1;
    @(negedge clk);
    chk("drop_exec_ready1", req1_ready, 32'd0);
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("drop_rsp_valid", rsp_valid, 32'd1);
    chk("drop_rsp_id", rsp_id, 32'd0);
    chk("drop_rsp_result", rsp_result, 32'h1234_5678);
    chk("drop_resp_ready1", req1_ready, 32'd0);
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("drop_no_rsp", rsp_valid, 32'd0);
      chk("drop_alu_a_held", alu_a, 32'h1234_0000);
    end
    @(posedge clk); #1;

    // Randomized single requests with random stalls.
    for (int i = 0; i < 24; i++) begin
      rm  = 1'($urandom_range(0, 1));
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = (i % 6 == 0) ? ra : ((i % 6 == 1) ? 32'd0 : $urandom);
      accept(rm, rop, ra, rb, w);
      exec_resp(rm, rop, ra, rb, $urandom_range(0, 2));
    end

    // Reset in the middle of EXEC discards the operation.
    accept(1'b1, 3'b010, 32'h0000_1111, 32'h0000_2222, w);
    #2 reset = 1'b1;
    #1;
    chk("midreset_alu_a", alu_a, 32'd0);
    chk("midreset_alu_b", alu_b, 32'd0);
    chk("midreset_alu_ctl", {alu_binvert, alu_carryin, alu_operation}, 32'd0);
    chk("midreset_rsp_valid", rsp_valid, 32'd0);
    chk("midreset_rsp_id", rsp_id, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("postreset_no_rsp", rsp_valid, 32'd0);
    end
    @(posedge clk); #1;

    // Contention: both masters valid every cycle, grants alternate starting with master 0.
    rsp_ready  = 1'b1;
    req1_op = 3'b010; req1_a = 32'd1; req1_b = 32'd1; req1_valid = 1'b1;
    req0_op = legal_ops[$urandom_range(0, 3)]; req0_a = $urandom; req0_b = $urandom; req0_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      w = 0;
      @(negedge clk);
      while (!(req0_ready || req1_ready) && w < 20) begin
        w++;
        @(negedge clk);
      end
      chk("cont_timeout", 32'(w < 20), 32'd1);
      chk("cont_exclusive", req0_ready & req1_ready, 32'd0);
      chk("cont_grant", req1_ready, 32'(k % 2));
      win = req1_ready;
      rop = win ? req1_op : req0_op;
      ra  = win ? req1_a  : req0_a;
      rb  = win ? req1_b  : req0_b;
      @(posedge clk); #1;
      if (!win) begin
        req0_op = legal_ops[$urandom_range(0, 3)]; req0_a = $urandom; req0_b = $urandom;
      end
      @(negedge clk);
      chk("cont_exec_ready", {req0_ready, req1_ready}, 32'd0);
      chk("cont_exec_valid", rsp_valid, 32'd0);
      @(negedge clk);
      e = ref_rsp(rop, ra, rb);
      chk("cont_rsp_valid", rsp_valid, 32'd1);
      chk("cont_rsp_id", rsp_id, win);
      chk("cont_rsp_result", rsp_result, e[31:0]);
      chk("cont_rsp_carry", rsp_carry, e[32]);
      @(posedge clk); #1;
      chk("cont_one_cycle_rsp", rsp_valid, 32'd0);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b0;
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter and sequencer for the shared 32-bit ALU (AND/OR/ADD/SUB with Binvert/Carryin/Operation controls). It accepts operation requests from two independent masters, grants the ALU round-robin, and drives the ALU control and operand inputs from registered values. It captures Result/CarryOut and returns them on a single tagged response channel with valid/ready backpressure. It sits between the instruction-side and auxiliary datapath clients and the single combinational ALU instance.

## Interface
- WIDTH, 32, operand/result width; must match the ALU instance.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0_valid, req1_valid  in  1  request present from master 0/1.
- req0_ready, req1_ready  out  1  request accepted this cycle (transfer = valid & ready).
- req0_op, req1_op  in  3  op code: 000 AND, 001 OR, 010 ADD, 110 SUB; all other codes are illegal.
- req0_a, req0_b, req1_a, req1_b  in  WIDTH  operands.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  1  index of the master that owns the response.
- rsp_result  out  WIDTH  captured ALU result.
- rsp_carry  out  1  captured ALU CarryOut.
- rsp_err  out  1  illegal op code.
- alu_a, alu_b  out  WIDTH  registered operands to ALU.
- alu_binvert, alu_carryin  out  1  both equal op[2].
- alu_operation  out  2  equals op[1:0].
- alu_result  in  WIDTH, alu_carryout  in  1  ALU outputs (combinational).

## Operation
- FSM has three states: IDLE, EXEC, RESP. Reset enters IDLE.
- IDLE:
  - Arbitrate. If exactly one valid, grant it. If both valid, grant the master not named by last_grant.
  - req_ready is combinational: asserted only to the granted master, only in IDLE.
  - On transfer: latch op/a/b into the operand registers, set owner=grant, set last_grant=grant, go to EXEC.
  - If no valid, stay in IDLE.
- EXEC:
  - alu_* outputs are already driven from the registers.
  - At the end of the cycle, capture alu_result/alu_carryout into the response registers and go to RESP.
  - For an illegal op, capture result=0, carry=0, err=1 instead.
- RESP:
  - rsp_valid=1; rsp_id/result/carry/err are held stable.
  - On rsp_valid & rsp_ready, go to IDLE. Otherwise stay in RESP.
- Masters hold valid and payload until ready. Dropping valid before ready is permitted and has no effect.
- Operand and response registers hold their values until overwritten. alu_* outputs stay at the last operation while idle.
- Arithmetic: SUB is a + ~b + 1 via the ALU. rsp_carry=1 means no borrow. No overflow flag is produced.
- Boundary conditions:
  - Both masters valid every cycle: grants strictly alternate.
  - A request arriving during EXEC/RESP waits. Its ready stays low and no request is dropped.
  - rsp_ready already high when RESP is entered: the response completes in one cycle.
  - Reset at any point returns to IDLE. The in-flight operation is discarded with no response.

## Timing
- Reset values:
  - State=IDLE; last_grant=1, so master 0 wins the first contention.
  - req*_ready=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_carry=0, rsp_err=0.
  - alu_a=alu_b=0, alu_binvert=alu_carryin=0, alu_operation=00.
- Latency: request accepted on edge N; alu_* show the new op after N; rsp_valid is asserted after edge N+1, i.e. visible in cycle N+2.
- Minimum issue interval is 3 cycles (accept, exec, respond). Back-to-back accepts are impossible.
- Each rsp_ready stall cycle adds one cycle to the interval.
- rsp_valid never deasserts without a handshake or reset.

## Test plan
- Single ops from master 0 with a=0xA5A5A5A5, b=0x5A5A5A5A:
  - AND -> result 0x00000000.
  - OR -> 0xFFFFFFFF.
  - ADD -> 0xFFFFFFFF, carry 0.
  - SUB -> 0x4B4B4B4B, carry 1.
  - Every case: rsp_id=0, err=0, rsp_valid 2 cycles after accept.
- Contention: both masters hold valid for 6 ops, master 1 doing ADD 1+1 -> grant order 0,1,0,1,0,1. Master 1 responses are 0x00000002 with rsp_id=1.
- Backpressure: rsp_ready low for 5 cycles in RESP -> rsp_valid and payload stable, both req_ready stay 0, and the next accept occurs the cycle after the handshake.
- Illegal op 011 and 100 -> rsp_err=1, result=0, carry=0, normal latency. The next legal op is unaffected.
- Reset asserted asynchronously mid-EXEC -> outputs go to reset values immediately and no response is issued. After release, master 0 wins contention.
- Master 1 drops valid before grant while master 0 is busy -> no master-1 op executes and no response carries rsp_id=1.
